// File: rtl/rv32i_exec_alu.sv
// Execute-stage ALU, branch comparator and immediate decoder for the torv32 RV32I core.
// Outputs are combinational by default; defining ALU_OUTREG_EN registers them (1-cycle latency).
module rv32i_exec_alu (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] inst,
  output logic [31:0] result,
  output logic        take_b,
  output logic [31:0] imm
);

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        f7_bit;
  logic [4:0]  shamt;
  logic        eq, lt_s, lt_u;
  alu_op_e     alu_op;
  logic [31:0] result_c;
  logic        take_c;
  logic [31:0] imm_c;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign f7_bit = inst[30];
  assign shamt  = in_b[4:0];
  assign eq     = (in_a == in_b);
  assign lt_s   = ($signed(in_a) < $signed(in_b));
  assign lt_u   = (in_a < in_b);

  // Only OP/OP-IMM decode funct3; elsewhere those bits may belong to an immediate.
  always_comb begin
    alu_op = ALU_ADD;
    if (opcode == OPC_OP || opcode == OPC_OP_IMM) begin
      case (funct3)
        3'b000:  alu_op = (opcode == OPC_OP && f7_bit) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_op = ALU_SLL;
        3'b010:  alu_op = ALU_SLT;
        3'b011:  alu_op = ALU_SLTU;
        3'b100:  alu_op = ALU_XOR;
        3'b101:  alu_op = f7_bit ? ALU_SRA : ALU_SRL;
        3'b110:  alu_op = ALU_OR;
        default: alu_op = ALU_AND;
      endcase
    end
  end

  always_comb begin
    result_c = '0;
    case (alu_op)
      ALU_ADD:  result_c = in_a + in_b;
      ALU_SUB:  result_c = in_a - in_b;
      ALU_SLL:  result_c = in_a << shamt;
      ALU_SLT:  result_c = {31'd0, lt_s};
      ALU_SLTU: result_c = {31'd0, lt_u};
      ALU_XOR:  result_c = in_a ^ in_b;
      ALU_SRL:  result_c = in_a >> shamt;
      ALU_SRA:  result_c = $signed(in_a) >>> shamt;
      ALU_OR:   result_c = in_a | in_b;
      ALU_AND:  result_c = in_a & in_b;
      default:  result_c = '0;
    endcase
  end

  always_comb begin
    take_c = 1'b0;
    if (opcode == OPC_BRANCH) begin
      case (funct3)
        3'b000:  take_c = eq;
        3'b001:  take_c = !eq;
        3'b100:  take_c = lt_s;
        3'b101:  take_c = !lt_s;
        3'b110:  take_c = lt_u;
        3'b111:  take_c = !lt_u;
        default: take_c = 1'b0;
      endcase
    end
  end

  always_comb begin
    imm_c = '0;
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR:
        imm_c = {{20{inst[31]}}, inst[31:20]};
      OPC_STORE:
        imm_c = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm_c = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_c = {inst[31:12], 12'd0};
      OPC_JAL:
        imm_c = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default:
        imm_c = '0;
    endcase
  end

`ifdef ALU_OUTREG_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      result <= '0;
      take_b <= 1'b0;
      imm    <= '0;
    end else begin
      result <= result_c;
      take_b <= take_c;
      imm    <= imm_c;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ resetn;
  assign result = result_c;
  assign take_b = take_c;
  assign imm    = imm_c;
`endif

endmodule

// File: tb/tb_rv32i_exec_alu.sv
// Scoreboard bench for rv32i_exec_alu: expectations are queued on drive and checked when outputs are valid.
// Works for both the default combinational build and the ALU_OUTREG_EN build.
module tb_rv32i_exec_alu;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] in_a, in_b, inst;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] imm;

  rv32i_exec_alu dut (
    .clk    (clk),
    .resetn (resetn),
    .in_a   (in_a),
    .in_b   (in_b),
    .inst   (inst),
    .result (result),
    .take_b (take_b),
    .imm    (imm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic        t;
    logic [31:0] m;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] i;
    logic [31:0] r;
    logic        t;
    logic [31:0] m;
  } vec_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic drive(input vec_t v);
    exp_t e;
    in_a = v.a;
    in_b = v.b;
    inst = v.i;
    e.r  = v.r;
    e.t  = v.t;
    e.m  = v.m;
    sb.push_back(e);
  endtask

  // Point at which outputs for the most recently driven inputs are valid.
  task automatic settle();
`ifdef ALU_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #2;
`endif
  endtask

  task automatic test_reset();
    exp_t e;
    vec_t v;
    resetn = 1'b0;
`ifdef ALU_OUTREG_EN
    v = '{a: 32'h1234, b: 32'h1234, i: 32'hFE000EE3, r: 32'h0, t: 1'b0, m: 32'h0};
`else
    // resetn has no effect on the combinational build
    v = '{a: 32'h1234, b: 32'h1234, i: 32'hFE000EE3, r: 32'h2468, t: 1'b1, m: 32'hFFFFFFFC};
`endif
    drive(v);
    settle();
    settle();
    e = sb.pop_front();
    n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL reset result got %h want %h", result, e.r); end
    n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL reset take_b got %b want %b", take_b, e.t); end
    n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL reset imm got %h want %h", imm, e.m); end
    resetn = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[12];
    exp_t e;
    v = '{
      '{32'h7FFFFFFF, 32'h1,        32'h003100B3, 32'h80000000, 1'b0, 32'h0},        // ADD overflow
      '{32'h0,        32'h1,        32'h403100B3, 32'hFFFFFFFF, 1'b0, 32'h0},        // SUB
      '{32'h5,        32'h3,        32'h40008093, 32'h8,        1'b0, 32'h400},      // ADDI inst30=1
      '{32'h80000000, 32'h401,      32'h4010D093, 32'hC0000000, 1'b0, 32'h401},      // SRAI
      '{32'h80000000, 32'h401,      32'h0010D093, 32'h40000000, 1'b0, 32'h1},        // SRLI
      '{32'hFFFFFFFF, 32'h1,        32'h003120B3, 32'h1,        1'b0, 32'h0},        // SLT
      '{32'hFFFFFFFF, 32'h1,        32'h003130B3, 32'h0,        1'b0, 32'h0},        // SLTU
      '{32'h1,        32'hFFFFFFE5, 32'h003110B3, 32'h20,       1'b0, 32'h0},        // SLL, upper bits ignored
      '{32'hF0F0F0F0, 32'hFF00FF00, 32'h003140B3, 32'h0FF00FF0, 1'b0, 32'h0},        // XOR
      '{32'h80000010, 32'h4,        32'h403150B3, 32'hF8000001, 1'b0, 32'h0},        // SRA
      '{32'hF0F0F0F0, 32'hFF00FF00, 32'h003160B3, 32'hFFF0FFF0, 1'b0, 32'h0},        // OR
      '{32'hF0F0F0F0, 32'hFF00FF00, 32'h003170B3, 32'hF000F000, 1'b0, 32'h0}         // AND
    };
    foreach (v[k]) begin
      drive(v[k]);
      settle();
      e = sb.pop_front();
      n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL arith[%0d] result got %h want %h", k, result, e.r); end
      n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL arith[%0d] take_b got %b want %b", k, take_b, e.t); end
      n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL arith[%0d] imm got %h want %h", k, imm, e.m); end
    end
  endtask

  task automatic test_branch();
    vec_t v[9];
    exp_t e;
    v = '{
      '{32'hFFFFFFFF, 32'h1,    32'hFE004EE3, 32'h0,    1'b1, 32'hFFFFFFFC},   // BLT
      '{32'hFFFFFFFF, 32'h1,    32'hFE006EE3, 32'h0,    1'b0, 32'hFFFFFFFC},   // BLTU
      '{32'h1234,     32'h1234, 32'hFE000EE3, 32'h2468, 1'b1, 32'hFFFFFFFC},   // BEQ equal
      '{32'h1234,     32'h1234, 32'hFE001EE3, 32'h2468, 1'b0, 32'hFFFFFFFC},   // BNE equal
      '{32'hFFFFFFFF, 32'h1,    32'hFE005EE3, 32'h0,    1'b0, 32'hFFFFFFFC},   // BGE
      '{32'hFFFFFFFF, 32'h1,    32'hFE007EE3, 32'h0,    1'b1, 32'hFFFFFFFC},   // BGEU
      '{32'h1234,     32'h1234, 32'hFE002EE3, 32'h2468, 1'b0, 32'hFFFFFFFC},   // funct3 010
      '{32'h1234,     32'h1234, 32'hFE003EE3, 32'h2468, 1'b0, 32'hFFFFFFFC},   // funct3 011
      '{32'h7,        32'h7,    32'h003100B3, 32'hE,    1'b0, 32'h0}           // OP equal operands
    };
    foreach (v[k]) begin
      drive(v[k]);
      settle();
      e = sb.pop_front();
      n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL branch[%0d] result got %h want %h", k, result, e.r); end
      n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL branch[%0d] take_b got %b want %b", k, take_b, e.t); end
      n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL branch[%0d] imm got %h want %h", k, imm, e.m); end
    end
  endtask

  task automatic test_immediates();
    vec_t v[8];
    exp_t e;
    v = '{
      '{32'h100,  32'h4,        32'h008000EF, 32'h104,      1'b0, 32'h8},          // JAL
      '{32'h100,  32'h4,        32'h008050EF, 32'h104,      1'b0, 32'h5008},       // JAL, funct3 bits set
      '{32'h1000, 32'h12345000, 32'h12345097, 32'h12346000, 1'b0, 32'h12345000},   // AUIPC
      '{32'h0,    32'h12345000, 32'h12345037, 32'h12345000, 1'b0, 32'h12345000},   // LUI
      '{32'h100,  32'hFFFFFFFC, 32'hFE112E23, 32'hFC,       1'b0, 32'hFFFFFFFC},   // store
      '{32'h200,  32'hFFFFFFFC, 32'hFFC02083, 32'h1FC,      1'b0, 32'hFFFFFFFC},   // load
      '{32'h300,  32'hFFFFFFFC, 32'hFFC080E7, 32'h2FC,      1'b0, 32'hFFFFFFFC},   // JALR
      '{32'h1,    32'h2,        32'h00100073, 32'h3,        1'b0, 32'h0}           // EBREAK
    };
    foreach (v[k]) begin
      drive(v[k]);
      settle();
      e = sb.pop_front();
      n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL imm[%0d] result got %h want %h", k, result, e.r); end
      n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL imm[%0d] take_b got %b want %b", k, take_b, e.t); end
      n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL imm[%0d] imm got %h want %h", k, imm, e.m); end
    end
  endtask

  task automatic test_latency();
    exp_t e;
    drive('{a: 32'h0, b: 32'h0, i: 32'h003100B3, r: 32'h0, t: 1'b0, m: 32'h0});
    settle();
    e = sb.pop_front();
    n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL latency_pre result got %h want %h", result, e.r); end
    drive('{a: 32'h2, b: 32'h3, i: 32'h003100B3, r: 32'h5, t: 1'b0, m: 32'h0});
    #2;
`ifdef ALU_OUTREG_EN
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL latency_hold result got %h want %h", result, 32'h0); end
    @(posedge clk);
    #1;
`endif
    e = sb.pop_front();
    n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL latency_add result got %h want %h", result, e.r); end
`ifdef ALU_OUTREG_EN
    resetn = 1'b0;
    drive('{a: 32'h1234, b: 32'h1234, i: 32'hFE000EE3, r: 32'h0, t: 1'b0, m: 32'h0});
    settle();
    e = sb.pop_front();
    n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL midreset result got %h want %h", result, e.r); end
    n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL midreset take_b got %b want %b", take_b, e.t); end
    n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL midreset imm got %h want %h", imm, e.m); end
    resetn = 1'b1;
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    vec_t v;
    for (int k = 0; k < 30; k++) begin
      v.a = $urandom;
      v.b = $urandom;
      v.t = 1'b0;
      v.m = 32'h0;
      case (k % 3)
        0: begin v.i = 32'h003100B3; v.r = v.a + v.b; end
        1: begin v.i = 32'h003140B3; v.r = v.a ^ v.b; end
        default: begin
          v.i = 32'h00006063;  // BLTU, zero offset
          v.r = v.a + v.b;
          v.t = (v.a < v.b);
        end
      endcase
      drive(v);
      settle();
      e = sb.pop_front();
      n_cmp++; if (result !== e.r) begin n_bad++; $display("FAIL b2b[%0d] result got %h want %h", k, result, e.r); end
      n_cmp++; if (take_b !== e.t) begin n_bad++; $display("FAIL b2b[%0d] take_b got %b want %b", k, take_b, e.t); end
      n_cmp++; if (imm !== e.m)    begin n_bad++; $display("FAIL b2b[%0d] imm got %h want %h", k, imm, e.m); end
    end
  endtask

  initial begin
    resetn = 1'b0;
    in_a   = '0;
    in_b   = '0;
    inst   = '0;
    #1;
    test_reset();
    test_arith();
    test_branch();
    test_immediates();
    test_latency();
    test_back_to_back();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain left %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
